// File: rtl/writeback_queue.sv
// Register-file writeback queue: merges ALU (src0, high priority) and load (src1)
// results into an in-order FIFO that drains one entry per cycle, with a decode bypass.
module writeback_queue #(
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         src0_valid,
    output logic                         src0_ready,
    input  logic [ADDR_WIDTH-1:0]        src0_addr,
    input  logic [BUS_WIDTH-1:0]         src0_data,
    input  logic                         src1_valid,
    output logic                         src1_ready,
    input  logic [ADDR_WIDTH-1:0]        src1_addr,
    input  logic [BUS_WIDTH-1:0]         src1_data,
    output logic                         rf_wr_en,
    output logic [ADDR_WIDTH-1:0]        rf_write_addr,
    output logic [BUS_WIDTH-1:0]         rf_data_in,
    input  logic [ADDR_WIDTH-1:0]        query_addr,
    output logic                         query_hit,
    output logic [BUS_WIDTH-1:0]         query_data,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [BUS_WIDTH-1:0]  data_q [DEPTH];
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;

    logic [CW-1:0]         free;
    logic                  push0, push1, pop;
    logic [PW-1:0]         slot0, slot1;

    // Ready looks only at registered occupancy, so a full queue is never
    // over-committed even if the same-cycle pop were ignored.
    assign free       = CW'(DEPTH) - count_q;
    assign src0_ready = rst_n && (free >= CW'(1));
    assign src1_ready = rst_n && ((free >= CW'(2)) || ((free >= CW'(1)) && !src0_valid));

    // Writes to register 0 finish the handshake but are discarded.
    assign push0 = src0_valid && src0_ready && (src0_addr != '0);
    assign push1 = src1_valid && src1_ready && (src1_addr != '0);
    assign pop   = (count_q != '0);

    assign slot0 = wr_ptr_q;
    assign slot1 = push0 ? wr_ptr_q + PW'(1) : wr_ptr_q;

    always_comb begin
        valid_d  = valid_q;
        if (pop)   valid_d[rd_ptr_q] = 1'b0;
        if (push0) valid_d[slot0]    = 1'b1;
        if (push1) valid_d[slot1]    = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(push0) + PW'(push1);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push0) + CW'(push1) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: occupancy is tracked by valid_q/count_q.
    always_ff @(posedge clk) begin
        if (push0) begin
            addr_q[slot0] <= src0_addr;
            data_q[slot0] <= src0_data;
        end
        if (push1) begin
            addr_q[slot1] <= src1_addr;
            data_q[slot1] <= src1_data;
        end
    end

    assign count         = count_q;
    assign rf_wr_en      = pop;
    assign rf_write_addr = pop ? addr_q[rd_ptr_q] : '0;
    assign rf_data_in    = pop ? data_q[rd_ptr_q] : '0;

    logic [DEPTH-1:0] match;
    logic [PW-1:0]    age_idx [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        assign match[gi]   = valid_q[gi] && (addr_q[gi] == query_addr);
        assign age_idx[gi] = rd_ptr_q + PW'(gi);
    end

    // Walk from oldest to youngest so the last hit is the most recent write.
    always_comb begin
        query_hit  = 1'b0;
        query_data = '0;
        if (query_addr != '0) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (match[age_idx[k]]) begin
                    query_hit  = 1'b1;
                    query_data = data_q[age_idx[k]];
                end
            end
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: cycle table plus reset and wrap sequences.
module tb_writeback_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        src0_valid, src1_valid;
    logic        src0_ready, src1_ready;
    logic [4:0]  src0_addr, src1_addr, query_addr;
    logic [31:0] src0_data, src1_data;
    logic        rf_wr_en;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_data_in;
    logic        query_hit;
    logic [31:0] query_data;
    logic [2:0]  count;

    writeback_queue #(.BUS_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .src0_valid(src0_valid), .src0_ready(src0_ready),
        .src0_addr(src0_addr), .src0_data(src0_data),
        .src1_valid(src1_valid), .src1_ready(src1_ready),
        .src1_addr(src1_addr), .src1_data(src1_data),
        .rf_wr_en(rf_wr_en), .rf_write_addr(rf_write_addr), .rf_data_in(rf_data_in),
        .query_addr(query_addr), .query_hit(query_hit), .query_data(query_data),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s0v;
        logic [4:0]  s0a;
        logic [31:0] s0d;
        logic        s1v;
        logic [4:0]  s1a;
        logic [31:0] s1d;
        logic [4:0]  qa;
        logic        r0, r1, wr;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        hit;
        logic [31:0] qd;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs [15];
    int   passed = 0;
    int   total  = 0;
    logic [4:0]  got_addr [$];
    logic [31:0] got_data [$];

    function automatic vec_t mk(logic s0v, logic [4:0] s0a, logic [31:0] s0d,
                                logic s1v, logic [4:0] s1a, logic [31:0] s1d,
                                logic [4:0] qa, logic r0, logic r1, logic wr,
                                logic [4:0] wa, logic [31:0] wd, logic hit,
                                logic [31:0] qd, logic [2:0] cnt);
        vec_t v;
        v.s0v = s0v; v.s0a = s0a; v.s0d = s0d;
        v.s1v = s1v; v.s1a = s1a; v.s1d = s1d;
        v.qa = qa; v.r0 = r0; v.r1 = r1; v.wr = wr; v.wa = wa; v.wd = wd;
        v.hit = hit; v.qd = qd; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic s0v, input logic [4:0] s0a, input logic [31:0] s0d,
                         input logic s1v, input logic [4:0] s1a, input logic [31:0] s1d,
                         input logic [4:0] qa);
        src0_valid = s0v; src0_addr = s0a; src0_data = s0d;
        src1_valid = s1v; src1_addr = s1a; src1_data = s1d;
        query_addr = qa;
    endtask

    initial begin
        // Queue contents noted after each row's edge.
        vecs[0]  = mk(0,0,0,           0,0,0,      0,  1,1,0, 0,0,            0,0,            0);
        vecs[1]  = mk(1,5,32'hDEADBEEF,0,0,0,      5,  1,1,0, 0,0,            0,0,            0);
        vecs[2]  = mk(0,0,0,           0,0,0,      5,  1,1,1, 5,32'hDEADBEEF, 1,32'hDEADBEEF, 1);
        vecs[3]  = mk(1,3,32'h11,      1,3,32'h22, 3,  1,1,0, 0,0,            0,0,            0);
        vecs[4]  = mk(0,0,0,           0,0,0,      3,  1,1,1, 3,32'h11,       1,32'h22,       2);
        vecs[5]  = mk(0,0,0,           0,0,0,      3,  1,1,1, 3,32'h22,       1,32'h22,       1);
        vecs[6]  = mk(0,0,0,           1,0,32'h55, 0,  1,1,0, 0,0,            0,0,            0);
        vecs[7]  = mk(0,0,0,           0,0,0,      0,  1,1,0, 0,0,            0,0,            0);
        vecs[8]  = mk(1,7,32'hA1,      1,8,32'hB2, 7,  1,1,0, 0,0,            0,0,            0);
        vecs[9]  = mk(1,9,32'hC3,      1,10,32'hD4,8,  1,1,1, 7,32'hA1,       1,32'hB2,       2);
        vecs[10] = mk(1,11,32'hE5,     1,12,32'hF6,9,  1,0,1, 8,32'hB2,       1,32'hC3,       3);
        vecs[11] = mk(0,0,0,           0,0,0,      12, 1,1,1, 9,32'hC3,       0,0,            3);
        vecs[12] = mk(0,0,0,           0,0,0,      11, 1,1,1, 10,32'hD4,      1,32'hE5,       2);
        vecs[13] = mk(0,0,0,           0,0,0,      11, 1,1,1, 11,32'hE5,      1,32'hE5,       1);
        vecs[14] = mk(0,0,0,           0,0,0,      0,  1,1,0, 0,0,            0,0,            0);

        rst_n = 1'b0;
        drive(1, 4, 32'h9, 1, 6, 32'h8, 4);
        #2;
        chk("reset src0_ready", 32'(src0_ready), 0);
        chk("reset src1_ready", 32'(src1_ready), 0);
        chk("reset rf_wr_en", 32'(rf_wr_en), 0);
        chk("reset count", 32'(count), 0);
        chk("reset query_hit", 32'(query_hit), 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(vecs[i].s0v, vecs[i].s0a, vecs[i].s0d, vecs[i].s1v, vecs[i].s1a, vecs[i].s1d, vecs[i].qa);
            #1;
            chk($sformatf("v%0d src0_ready", i), 32'(src0_ready), 32'(vecs[i].r0));
            chk($sformatf("v%0d src1_ready", i), 32'(src1_ready), 32'(vecs[i].r1));
            chk($sformatf("v%0d rf_wr_en", i), 32'(rf_wr_en), 32'(vecs[i].wr));
            chk($sformatf("v%0d rf_write_addr", i), 32'(rf_write_addr), 32'(vecs[i].wa));
            chk($sformatf("v%0d rf_data_in", i), rf_data_in, vecs[i].wd);
            chk($sformatf("v%0d query_hit", i), 32'(query_hit), 32'(vecs[i].hit));
            chk($sformatf("v%0d query_data", i), query_data, vecs[i].qd);
            chk($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].cnt));
            $display("vec %0d: wr=%0d addr=%0d data=0x%0h hit=%0d qdata=0x%0h count=%0d",
                     i, rf_wr_en, rf_write_addr, rf_data_in, query_hit, query_data, count);
        end

        // Reset pulse with two writes pending.
        @(negedge clk);
        drive(1, 4, 32'h44, 1, 6, 32'h66, 4);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 4);
        #1;
        chk("pre-reset count", 32'(count), 2);
        rst_n = 1'b0;
        src0_valid = 1'b1;
        #1;
        chk("midreset count", 32'(count), 0);
        chk("midreset rf_wr_en", 32'(rf_wr_en), 0);
        chk("midreset query_hit", 32'(query_hit), 0);
        chk("midreset query_data", query_data, 0);
        chk("midreset src0_ready", 32'(src0_ready), 0);
        chk("midreset src1_ready", 32'(src1_ready), 0);
        $display("reset pulse: count=%0d wr=%0d hit=%0d", count, rf_wr_en, query_hit);
        @(negedge clk);
        src0_valid = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post-reset c%0d rf_wr_en", c), 32'(rf_wr_en), 0);
            chk($sformatf("post-reset c%0d count", c), 32'(count), 0);
        end
        @(negedge clk);
        drive(1, 2, 32'h77, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("post-reset write en", 32'(rf_wr_en), 1);
        chk("post-reset write addr", 32'(rf_write_addr), 2);
        chk("post-reset write data", rf_data_in, 32'h77);
        $display("post-reset request: wr=%0d addr=%0d data=0x%0h", rf_wr_en, rf_write_addr, rf_data_in);

        // Ten back-to-back src0 pushes; pointers wrap twice.
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c < 10) drive(1, 5'(c + 1), 32'h1000 + 32'(c + 1), 0, 0, 0, 0);
            else        drive(0, 0, 0, 0, 0, 0, 0);
            #1;
            if (c < 10) chk($sformatf("b2b c%0d src0_ready", c), 32'(src0_ready), 1);
            if (rf_wr_en) begin
                got_addr.push_back(rf_write_addr);
                got_data.push_back(rf_data_in);
            end
        end
        chk("b2b write count", 32'(got_addr.size()), 10);
        for (int k = 0; k < 10; k++) begin
            if (k < got_addr.size()) begin
                chk($sformatf("b2b w%0d addr", k), 32'(got_addr[k]), 32'(k + 1));
                chk($sformatf("b2b w%0d data", k), got_data[k], 32'h1000 + 32'(k + 1));
                $display("b2b write %0d: addr=%0d data=0x%0h", k, got_addr[k], got_data[k]);
            end
        end
        chk("b2b final count", 32'(count), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 The module SHALL have parameter BUS_WIDTH, default 32, meaning the data word width.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 5, meaning the register address width (32 registers).
REQ-003 The module SHALL have parameter DEPTH, default 4, meaning the queue entry count (power of two, at least 2).
REQ-004 The module SHALL have one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 src0_valid / src0_ready  input / output  1 / 1  handshake for ALU-result write requests (high priority).
REQ-008 src0_addr / src0_data  input / input  ADDR_WIDTH / BUS_WIDTH  destination register and value for source 0.
REQ-009 src1_valid / src1_ready  input / output  1 / 1  handshake for load-result write requests (low priority).
REQ-010 src1_addr / src1_data  input / input  ADDR_WIDTH / BUS_WIDTH  destination register and value for source 1.
REQ-011 rf_wr_en / rf_write_addr / rf_data_in  output / output / output  1 / ADDR_WIDTH / BUS_WIDTH  drive the register-file write port.
REQ-012 query_addr  input  ADDR_WIDTH  register address being read by the decode stage.
REQ-013 query_hit / query_data  output / output  1 / BUS_WIDTH  pending-write bypass result for query_addr.
REQ-014 count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-015 A request SHALL be accepted on a rising edge where valid and ready are both high.
REQ-016 Ready SHALL be computed from registered count only, with free = DEPTH - count: src0_ready = (free >= 1); src1_ready = (free >= 2) or (free >= 1 and not src0_valid).
REQ-017 If both sources are accepted on the same edge, the src0 entry SHALL be enqueued as older than the src1 entry.
REQ-018 An accepted request with address 0 SHALL complete the handshake and SHALL NOT be enqueued.
REQ-019 rf_wr_en SHALL equal (count != 0), and rf_write_addr and rf_data_in SHALL equal the head entry combinationally from registered state.
REQ-020 On every edge where count != 0, the head entry SHALL be dequeued, so the register-file write occurs on that same edge.
REQ-021 Latency from acceptance edge N to the register-file write edge SHALL be exactly one cycle when the queue is empty before edge N.
REQ-022 Push and pop on the same edge SHALL both take effect, giving count_next = count + pushes - pop, with pushes in 0..2.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH.
REQ-024 count SHALL never exceed DEPTH; the ready rule in REQ-016 SHALL guarantee this without relying on a same-cycle pop.
REQ-025 query_hit SHALL be 1 when query_addr != 0 and any occupied entry holds query_addr.
REQ-026 When query_hit is 1, query_data SHALL equal the data of the youngest matching entry.
REQ-027 When query_hit is 0, query_data SHALL be 0.
REQ-028 query_hit and query_data SHALL be combinational from query_addr and registered state; the same-cycle src0/src1 inputs SHALL NOT be forwarded.
REQ-029 Entries SHALL be written to the register file in enqueue order; writes to the same register SHALL never be reordered.

Reset
REQ-030 While rst_n is low, count, the pointers and the entry valid state SHALL be 0 and all pending entries SHALL be discarded.
REQ-031 While rst_n is low, rf_wr_en, query_hit and query_data SHALL be 0, and src0_ready and src1_ready SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL drop queued writes with no partial register-file write, and no write SHALL occur on the first edge after deassertion.

Verification
REQ-033 The bench SHALL cover: empty queue, src0 {addr 5, data 0xDEADBEEF} accepted at edge N -> rf_wr_en=1, addr 5, data 0xDEADBEEF in cycle N+1, count back to 0 after edge N+1.
REQ-034 The bench SHALL cover: both sources valid on an empty queue, src0 {3, 0x11} and src1 {3, 0x22} -> writes on consecutive edges in order 0x11 then 0x22, query_addr=3 gives hit with 0x22 after the first write and 0x22 before it.
REQ-035 The bench SHALL cover: src1 valid with addr 0 -> handshake completes, count stays 0, rf_wr_en stays 0; query_addr=0 -> query_hit=0.
REQ-036 The bench SHALL cover: count=3 with DEPTH=4 and both sources valid -> src0_ready=1, src1_ready=0; only src0 accepted; count stays 3 because pop and push coincide.
REQ-037 The bench SHALL cover: rst_n pulsed low mid-stream with count=2 -> outputs 0 immediately; after release no register-file write until a new request is accepted.
REQ-038 The bench SHALL cover: 10 back-to-back src0 pushes with addresses 1..10 -> pointer wrap exercised, and the register-file write sequence is exactly 1..10 with matching data.
